// File: rtl/sram_rom_word_fetch.sv
// Fetches 16-bit ROM words for the game core from an 8-bit external SRAM as two byte reads,
// and hands the SRAM bus to the data pump while it is loading the ROM image.
module sram_rom_word_fetch #(
  parameter logic [18:0] BASE_ADDR   = 19'h00000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock_48,
  input  logic        reset,
  input  logic [13:0] rom_addr,
  output logic [15:0] rom_do,
  output logic        rom_valid,
  input  logic        pump_active,
  input  logic [18:0] pump_addr,
  input  logic [7:0]  pump_data,
  input  logic        pump_we_n,
  output logic [18:0] sram_addr_o,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe,
  input  logic [7:0]  sram_data_i,
  output logic        sram_we_n_o,
  output logic        sram_oe_n_o
);

  typedef enum logic [2:0] {IDLE, LO_WAIT, LO_CAP, HI_WAIT, HI_CAP} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [13:0] a_q;
  logic [13:0] cache_addr_q;
  logic        cache_vld_q;
  logic [7:0]  lo_q;
  logic [15:0] rom_do_q;
  logic        rom_valid_q;
  logic [18:0] sram_addr_q;
  logic [7:0]  sram_data_q;
  logic        sram_data_oe_q;
  logic        sram_we_n_q;
  logic        sram_oe_n_q;

  // Byte address of one half of a ROM word; 19-bit add wraps by construction.
  function automatic logic [18:0] byte_addr(input logic [13:0] a, input logic odd);
    return BASE_ADDR + {4'b0, a, odd};
  endfunction

  always_ff @(posedge clock_48) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      a_q            <= '0;
      cache_addr_q   <= '0;
      cache_vld_q    <= 1'b0;
      lo_q           <= '0;
      rom_do_q       <= '0;
      rom_valid_q    <= 1'b0;
      sram_addr_q    <= BASE_ADDR;
      sram_data_q    <= '0;
      sram_data_oe_q <= 1'b0;
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
    end else if (pump_active) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cache_vld_q    <= 1'b0;
      rom_valid_q    <= 1'b0;
      sram_addr_q    <= pump_addr;
      sram_data_q    <= pump_data;
      sram_we_n_q    <= pump_we_n;
      sram_data_oe_q <= 1'b1;
      sram_oe_n_q    <= 1'b1;
    end else begin
      sram_data_oe_q <= 1'b0;
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!cache_vld_q || rom_addr != cache_addr_q) begin
            a_q         <= rom_addr;
            sram_addr_q <= byte_addr(rom_addr, 1'b0);
            rom_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= LO_WAIT;
          end
        end
        LO_WAIT, LO_CAP, HI_WAIT: begin
          // A moved address abandons the partial word; rom_do keeps the last committed one.
          if (rom_addr != a_q) begin
            a_q         <= rom_addr;
            sram_addr_q <= byte_addr(rom_addr, 1'b0);
            cnt_q       <= '0;
            state_q     <= LO_WAIT;
          end else if (state_q == LO_CAP) begin
            lo_q        <= sram_data_i;
            sram_addr_q <= byte_addr(a_q, 1'b1);
            state_q     <= HI_WAIT;
          end else if (cnt_q == WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= (state_q == LO_WAIT) ? LO_CAP : HI_CAP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        HI_CAP: begin
          rom_do_q     <= {sram_data_i, lo_q};
          cache_addr_q <= a_q;
          cache_vld_q  <= 1'b1;
          rom_valid_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_do       = rom_do_q;
  assign rom_valid    = rom_valid_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_data_o  = sram_data_q;
  assign sram_data_oe = sram_data_oe_q;
  assign sram_we_n_o  = sram_we_n_q;
  assign sram_oe_n_o  = sram_oe_n_q;

endmodule

// File: tb/tb_sram_rom_word_fetch.sv
// Directed bench: SRAM byte model, commit scoreboard, and a second instance at a high BASE_ADDR.
module tb_sram_rom_word_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] rom_addr, rom_addr2;
  logic [15:0] rom_do, rom_do2;
  logic        rom_valid, rom_valid2;
  logic        pump_active, pump_off;
  logic [18:0] pump_addr;
  logic [7:0]  pump_data;
  logic        pump_we_n;
  logic [18:0] sram_addr_o, sram_addr2;
  logic [7:0]  sram_data_o, sram_data2;
  logic        sram_data_oe, sram_data_oe2;
  logic [7:0]  sram_data_i, sram_data_i2;
  logic        sram_we_n_o, sram_we_n2;
  logic        sram_oe_n_o, sram_oe_n2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  bit [7:0] mem [0:524287];
  bit       mem_init_done = 1'b0;
  bit       vprev = 1'b0;

  always #5 clk = ~clk;

  sram_rom_word_fetch dut (
    .clock_48(clk), .reset(reset), .rom_addr(rom_addr), .rom_do(rom_do), .rom_valid(rom_valid),
    .pump_active(pump_active), .pump_addr(pump_addr), .pump_data(pump_data), .pump_we_n(pump_we_n),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_we_n_o(sram_we_n_o), .sram_oe_n_o(sram_oe_n_o));

  sram_rom_word_fetch #(.BASE_ADDR(19'h40000)) dut2 (
    .clock_48(clk), .reset(reset), .rom_addr(rom_addr2), .rom_do(rom_do2), .rom_valid(rom_valid2),
    .pump_active(pump_off), .pump_addr(pump_addr), .pump_data(pump_data), .pump_we_n(pump_we_n),
    .sram_addr_o(sram_addr2), .sram_data_o(sram_data2), .sram_data_oe(sram_data_oe2),
    .sram_data_i(sram_data_i2), .sram_we_n_o(sram_we_n2), .sram_oe_n_o(sram_oe_n2));

  assign sram_data_i  = mem[sram_addr_o];
  assign sram_data_i2 = mem[sram_addr2];

  // SRAM model: preloaded image on the first edge, then pump writes.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem[19'h00000] <= 8'h12; mem[19'h00001] <= 8'h34;
      mem[19'h00004] <= 8'h21; mem[19'h00005] <= 8'h43;
      mem[19'h0000A] <= 8'hAA; mem[19'h0000B] <= 8'h55;
      mem[19'h0000C] <= 8'h66; mem[19'h0000D] <= 8'h77;
      mem[19'h00011] <= 8'h5A;
      mem[19'h47FFE] <= 8'hBE; mem[19'h47FFF] <= 8'hEF;
      mem_init_done  <= 1'b1;
    end else if (sram_data_oe && !sram_we_n_o) begin
      mem[sram_addr_o] <= sram_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every rising rom_valid is a commit and must match the oldest expected word.
  always @(negedge clk) begin
    if (rom_valid === 1'b1 && !vprev) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL commit_unexpected: observed %h expected no commit", rom_do);
      end
      if (exp_q.size() != 0) chk("commit_word", {16'h0, rom_do}, {16'h0, exp_q.pop_front()});
    end
    vprev <= (rom_valid === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_commit(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; rom_addr = 14'h0000; rom_addr2 = 14'h3FFF;
    pump_active = 1'b0; pump_off = 1'b0; pump_addr = '0; pump_data = '0; pump_we_n = 1'b1;
    cycles(3);
    chk("rst_rom_valid", rom_valid, 0);
    chk("rst_rom_do", rom_do, 0);
    chk("rst_sram_addr", sram_addr_o, 0);
    chk("rst_sram_addr2", sram_addr2, 32'h40000);
    chk("rst_oe", sram_data_oe, 0);
    chk("rst_we_n", sram_we_n_o, 1);
    chk("rst_oe_n", sram_oe_n_o, 1);

    // First fetch of word 0 and of word 3FFF at BASE 40000, 7-clock latency.
    exp_q.push_back(16'h3412);
    reset = 1'b0;
    cycles(1);
    chk("w0_lo_addr", sram_addr_o, 0);
    chk("w0_oe_n", sram_oe_n_o, 0);
    chk("top_lo_addr", sram_addr2, 32'h47FFE);
    cycles(3);
    chk("w0_hi_addr", sram_addr_o, 1);
    chk("top_hi_addr", sram_addr2, 32'h47FFF);
    cycles(2);
    chk("w0_valid_early", rom_valid, 0);
    cycles(1);
    chk("w0_valid", rom_valid, 1);
    chk("w0_data", rom_do, 16'h3412);
    chk("top_valid", rom_valid2, 1);
    chk("top_data", rom_do2, 16'hEFBE);
    wait_commit("w0_drain");

    // Word 5: addresses 0A/0B, old word held until commit.
    exp_q.push_back(16'h55AA);
    rom_addr = 14'h0005;
    cycles(1);
    chk("w5_lo_addr", sram_addr_o, 32'h0000A);
    chk("w5_valid_drop", rom_valid, 0);
    chk("w5_hold0", rom_do, 16'h3412);
    cycles(3);
    chk("w5_hi_addr", sram_addr_o, 32'h0000B);
    cycles(2);
    chk("w5_hold1", rom_do, 16'h3412);
    cycles(1);
    chk("w5_data", rom_do, 16'h55AA);
    wait_commit("w5_drain");

    // Abort: start word 5 again (via word 2), move to word 6 during HI_WAIT.
    exp_q.push_back(16'h4321);
    rom_addr = 14'h0002;
    wait_commit("w2_drain");
    rom_addr = 14'h0005;
    cycles(4);
    chk("abort_hi_addr", sram_addr_o, 32'h0000B);
    exp_q.push_back(16'h7766);
    rom_addr = 14'h0006;
    cycles(1);
    chk("abort_restart_addr", sram_addr_o, 32'h0000C);
    chk("abort_hold", rom_do, 16'h4321);
    wait_commit("abort_drain");
    chk("abort_data", rom_do, 16'h7766);

    // Pump takes the bus mid-fetch and writes C3 to byte 10.
    rom_addr = 14'h0008;
    cycles(2);
    pump_active = 1'b1; pump_addr = 19'h00010; pump_data = 8'hC3; pump_we_n = 1'b1;
    chk("pre_pump_oe_n", sram_oe_n_o, 0);
    cycles(1);
    chk("pump_oe", sram_data_oe, 1);
    chk("pump_oe_n", sram_oe_n_o, 1);
    chk("pump_addr", sram_addr_o, 32'h00010);
    chk("pump_data", sram_data_o, 8'hC3);
    chk("pump_valid", rom_valid, 0);
    pump_we_n = 1'b0;
    cycles(1);
    chk("pump_we_low", sram_we_n_o, 0);
    pump_we_n = 1'b1;
    cycles(1);
    chk("pump_we_high", sram_we_n_o, 1);
    exp_q.push_back(16'h5AC3);
    pump_active = 1'b0;
    cycles(1);
    chk("post_pump_oe", sram_data_oe, 0);
    chk("post_pump_oe_n", sram_oe_n_o, 0);
    chk("post_pump_addr", sram_addr_o, 32'h00010);
    wait_commit("pump_drain");

    // Reset during LO_WAIT.
    rom_addr = 14'h0005;
    cycles(1);
    chk("rst2_lo_addr", sram_addr_o, 32'h0000A);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    chk("rst2_addr", sram_addr_o, 0);
    chk("rst2_rom_do", rom_do, 0);
    chk("rst2_valid", rom_valid, 0);
    chk("rst2_oe_n", sram_oe_n_o, 1);
    exp_q.push_back(16'h55AA);
    reset = 1'b0;
    cycles(1);
    chk("rst2_restart_addr", sram_addr_o, 32'h0000A);
    chk("rst2_restart_oe_n", sram_oe_n_o, 0);
    wait_commit("rst2_drain");

    // Address change on the HI_CAP clock: old word commits, then refetch.
    exp_q.push_back(16'h7766);
    rom_addr = 14'h0006;
    cycles(6);
    exp_q.push_back(16'h3412);
    rom_addr = 14'h0000;
    cycles(1);
    chk("hicap_commit", rom_do, 16'h7766);
    cycles(1);
    chk("hicap_valid_drop", rom_valid, 0);
    chk("hicap_refetch_addr", sram_addr_o, 0);
    wait_commit("hicap_drain");
    chk("hicap_final", rom_do, 16'h3412);

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
